// File: rtl/dptr_multiciclo.sv
// Multi-cycle MIPS-subset datapath: IDLE/DECODE/EXEC/MEM/WB controller, register file,
// ALU and word-addressed data memory. Executes one instruction at a time.
module dptr_multiciclo #(
  parameter int DATA_W    = 32,
  parameter int NREG      = 32,
  parameter int MEM_DEPTH = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  input  logic [31:0]       instr,
  output logic              instr_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              zf,
  output logic [DATA_W-1:0] res
);

  localparam int RW = $clog2(NREG);
  localparam int AW = $clog2(MEM_DEPTH);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_SLT   = 6'b101010;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_R: begin
        case (fn)
          F_ADD, F_SUB, F_AND, F_OR, F_SLT: ok = 1'b1;
          default:                          ok = 1'b0;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: ok = 1'b1;
      default:               ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [DATA_W-1:0] sext(input logic [15:0] imm);
    return {{(DATA_W-16){imm[15]}}, imm};
  endfunction

  state_t              state_r, state_s;
  logic                done_s, err_s;
  logic                done_r, err_r, ready_r, busy_r;
  logic [31:0]         instr_r;
  logic [DATA_W-1:0]   opa_r, opb_r, res_r, mdr_r, alu_s;
  logic                zf_r;
  logic [DATA_W-1:0]   regs_r [NREG];
  logic [DATA_W-1:0]   mem_r  [MEM_DEPTH];

  logic [5:0]          op_s, funct_s;
  logic [RW-1:0]       rs_s, rt_s, rd_s, wr_idx_s;
  logic [DATA_W-1:0]   wr_data_s;
  logic [AW-1:0]       maddr_s;
  logic                unused_s;

  assign op_s      = instr_r[31:26];
  assign funct_s   = instr_r[5:0];
  assign rs_s      = instr_r[21 +: RW];
  assign rt_s      = instr_r[16 +: RW];
  assign rd_s      = instr_r[11 +: RW];
  assign wr_idx_s  = (op_s == OP_R) ? rd_s : rt_s;
  assign wr_data_s = (op_s == OP_LW) ? mdr_r : res_r;
  // MEM_DEPTH is a power of two, so the low address bits give the modulo wrap.
  assign maddr_s   = res_r[AW-1:0];
  assign unused_s  = ^instr_r[10:6];

  assign instr_ready = ready_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign err         = err_r;
  assign zf          = zf_r;
  assign res         = res_r;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state plus done/err for the state being entered, so the pulses come from flops.
  always_comb begin
    state_s = state_r;
    done_s  = 1'b0;
    err_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (instr_valid) begin
          state_s = S_DECODE;
          if (!is_legal(instr[31:26], instr[5:0])) begin
            done_s = 1'b1;
            err_s  = 1'b1;
          end else begin
            done_s = 1'b0;
            err_s  = 1'b0;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_DECODE: begin
        if (is_legal(op_s, funct_s)) begin
          state_s = S_EXEC;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_EXEC: begin
        if (op_s == OP_LW || op_s == OP_SW) begin
          state_s = S_MEM;
        end else begin
          state_s = S_WB;
        end
        // Everything except LW retires in the state after EXEC.
        done_s = (op_s != OP_LW);
      end
      S_MEM: begin
        if (op_s == OP_LW) begin
          state_s = S_WB;
          done_s  = 1'b1;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_WB:    state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Handshake and retirement outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      ready_r <= (state_s == S_IDLE);
      busy_r  <= (state_s != S_IDLE);
      done_r  <= done_s;
      err_r   <= err_s;
    end
  end

  // ALU; ADDI, LW and SW all compute base plus sign-extended offset.
  always_comb begin
    alu_s = '0;
    if (op_s == OP_R) begin
      case (funct_s)
        F_ADD:   alu_s = opa_r + opb_r;
        F_SUB:   alu_s = opa_r - opb_r;
        F_AND:   alu_s = opa_r & opb_r;
        F_OR:    alu_s = opa_r | opb_r;
        F_SLT:   alu_s = ($signed(opa_r) < $signed(opb_r)) ? {{(DATA_W-1){1'b0}}, 1'b1} : '0;
        default: alu_s = '0;
      endcase
    end else begin
      alu_s = opa_r + sext(instr_r[15:0]);
    end
  end

  // Instruction latch, operand registers, result/flag and memory data register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_r <= 32'd0;
      opa_r   <= '0;
      opb_r   <= '0;
      res_r   <= '0;
      zf_r    <= 1'b0;
      mdr_r   <= '0;
    end else begin
      if (state_r == S_IDLE && instr_valid) begin
        instr_r <= instr;
      end
      if (state_r == S_DECODE) begin
        opa_r <= (rs_s == '0) ? '0 : regs_r[rs_s];
        opb_r <= (rt_s == '0) ? '0 : regs_r[rt_s];
      end
      if (state_r == S_EXEC) begin
        res_r <= alu_s;
        zf_r  <= (alu_s == '0);
      end
      if (state_r == S_MEM && op_s == OP_LW) begin
        mdr_r <= mem_r[maddr_s];
      end
    end
  end

  // Register file; register 0 is never written so it always reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= '0;
      end
    end else if (state_r == S_WB && wr_idx_s != '0) begin
      regs_r[wr_idx_s] <= wr_data_s;
    end
  end

  // Data memory; SW commits on the edge leaving MEM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (state_r == S_MEM && op_s == OP_SW) begin
      mem_r[maddr_s] <= opb_r;
    end
  end

endmodule

// File: doc/dptr_multiciclo.md
DPTR_MULTICICLO -- requirements
Module: dptr_multiciclo

Interface
REQ-001 Parameter DATA_W, default 32: width of registers, ALU operands and data memory words.
REQ-002 Parameter NREG, default 32: register count; register index width is clog2(NREG).
REQ-003 Parameter MEM_DEPTH, default 64: data memory word count; word address width is clog2(MEM_DEPTH).
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  reset; asynchronous, active-low.
REQ-006 instr_valid  in  1  instr holds an instruction for issue.
REQ-007 instr  in  32  MIPS-format instruction (opcode[31:26], rs[25:21], rt[20:16], rd[15:11], funct[5:0], imm[15:0]).
REQ-008 instr_ready  out  1  high only in IDLE; an instruction is accepted when instr_valid and instr_ready are both high at a clock edge.
REQ-009 busy  out  1  high in every state except IDLE.
REQ-010 done  out  1  one-cycle pulse marking retirement of the accepted instruction.
REQ-011 err  out  1  one-cycle pulse, coincident with done, for an unsupported opcode or funct.
REQ-012 zf  out  1  zero flag of the last EXEC result, held until the next EXEC.
REQ-013 res  out  DATA_W  last EXEC ALU result, held until the next EXEC.

Function
REQ-014 Register indices use the low clog2(NREG) bits of each field; register 0 reads as 0, and writes to it are discarded.
REQ-015 R-type (opcode 000000) funct values: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT (signed, result 1 or 0); rd <- rs op rt.
REQ-016 ADDI (001000): rt <- rs + sign_extend(imm).
REQ-017 LW (100011): rt <- mem[(rs + sign_extend(imm)) mod MEM_DEPTH].
REQ-018 SW (101011): mem[(rs + sign_extend(imm)) mod MEM_DEPTH] <- rt.
REQ-019 Arithmetic is DATA_W bits and wraps modulo 2^DATA_W; imm is sign-extended to DATA_W; no overflow trap.
REQ-020 FSM states: IDLE, DECODE, EXEC, MEM, WB; each non-IDLE state lasts exactly one cycle.
REQ-021 IDLE: on accept, instr is latched and the FSM goes to DECODE; otherwise it stays in IDLE.
REQ-022 DECODE: rs and rt are read into operand registers; a legal instruction goes to EXEC, an illegal one goes to IDLE with done=err=1 and no state change.
REQ-023 EXEC: the ALU result is captured into res and zf; R-type and ADDI go to WB, LW and SW go to MEM.
REQ-024 MEM: LW captures the memory word and goes to WB; SW writes memory at the edge leaving MEM and goes to IDLE with done=1 during MEM.
REQ-025 WB: the destination register is written at the edge leaving WB; done=1 during WB; next state is IDLE.
REQ-026 Latency from the accept edge to the done cycle: R-type/ADDI 3 cycles, SW 3 cycles, LW 4 cycles, illegal 1 cycle.
REQ-027 instr and instr_valid are ignored while busy; the next accept is possible in the cycle after done.
REQ-028 An instruction reading a register written by the previous instruction sees the new value; operands are read in DECODE, after the prior WB.
REQ-029 done and err are never high outside the retiring state; at most one done pulse per accepted instruction.

Reset
REQ-030 rst_n low immediately forces IDLE, clears all registers and memory words to 0, and drives busy=done=err=zf=0, res=0, instr_ready=1.
REQ-031 Reset mid-instruction aborts it: no register or memory write, no done pulse.
REQ-032 After rst_n rises, the first accept is possible at the next rising edge.

Verification
REQ-033 After reset, issue ADDI r1,r0,5 then ADDI r2,r0,-3 -> each done 3 cycles after accept; r1=5, r2=0xFFFFFFFD.
REQ-034 After REQ-033, issue ADD r3,r1,r2 -> res=2, zf=0; then SUB r4,r1,r1 -> res=0, zf=1; then SLT r5,r2,r1 -> r5=1.
REQ-035 Issue SW r1,4(r0) then LW r6,4(r0) -> SW done 3 cycles after accept; LW done 4 cycles after accept; r6=5; LW 70(r0) with MEM_DEPTH=64 reads word 6.
REQ-036 Issue opcode 111111 -> done=err=1 one cycle after accept; no register or memory changes; instr_ready high the next cycle.
REQ-037 Assert rst_n low during the EXEC of ADDI r7,r0,9 -> no done; r7=0; outputs at reset values.
REQ-038 Hold instr_valid high with changing instr while busy -> only the accepted instruction executes; ADDI r0,r0,1 leaves r0=0.
